// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU mode codes, the highest
// legal mode, and the arbiter FSM state encoding.
package alu_pkg;

  localparam int WIDTH  = 32;
  localparam int MODE_W = 4;

  localparam logic [MODE_W-1:0] ALU_ADD     = 4'd0;
  localparam logic [MODE_W-1:0] ALU_SUB     = 4'd1;
  localparam logic [MODE_W-1:0] ALU_AND     = 4'd2;
  localparam logic [MODE_W-1:0] ALU_OR      = 4'd3;
  localparam logic [MODE_W-1:0] ALU_XOR     = 4'd4;
  localparam logic [MODE_W-1:0] ALU_SLL     = 4'd5;
  localparam logic [MODE_W-1:0] ALU_SRL     = 4'd6;
  localparam logic [MODE_W-1:0] ALU_SRA     = 4'd7;
  localparam logic [MODE_W-1:0] ALU_SLT     = 4'd8;
  localparam logic [MODE_W-1:0] ALU_SLTU    = 4'd9;
  localparam logic [MODE_W-1:0] ALU_ADDSHL2 = 4'd10;

  localparam logic [MODE_W-1:0] ALU_MAX_MODE = ALU_ADDSHL2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// port that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between the execute stage (port 0)
// and the branch/address unit (port 1), with registered operands and result.
//
// state | meaning
// IDLE  | waiting for a request; grant one port and latch its operands
// EXEC  | ALU enabled with latched operands; result captured at the edge
// DONE  | result presented to the granted port until rsp_ready
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int                WIDTH    = alu_pkg::WIDTH,
  parameter int                MODE_W   = alu_pkg::MODE_W,
  parameter logic [MODE_W-1:0] MAX_MODE = ALU_MAX_MODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_op1,
  input  logic [WIDTH-1:0]  req0_op2,
  input  logic [MODE_W-1:0] req0_mode,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_op1,
  input  logic [WIDTH-1:0]  req1_op2,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [WIDTH-1:0]  alu_operand1,
  output logic [WIDTH-1:0]  alu_operand2,
  output logic [MODE_W-1:0] alu_mode,
  output logic              alu_en,
  input  logic [WIDTH-1:0]  alu_out
);

  state_t     state;
  logic       last_grant;
  logic       grant_id;
  logic [1:0] gnt;
  logic       mode_bad;

  rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Gating with rst keeps a request from being handshaken during a reset cycle.
  assign req0_ready = (state == ST_IDLE) && !rst && gnt[0];
  assign req1_ready = (state == ST_IDLE) && !rst && gnt[1];
  assign mode_bad   = (alu_mode > MAX_MODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      alu_en       <= 1'b0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_mode     <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            grant_id     <= gnt[1];
            last_grant   <= gnt[1];
            alu_en       <= 1'b1;
            alu_operand1 <= gnt[1] ? req1_op1  : req0_op1;
            alu_operand2 <= gnt[1] ? req1_op2  : req0_op2;
            alu_mode     <= gnt[1] ? req1_mode : req0_mode;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_err      <= mode_bad;
          rsp_data     <= mode_bad ? '0 : alu_out;
          rsp0_valid   <= !grant_id;
          rsp1_valid   <= grant_id;
          alu_en       <= 1'b0;
          alu_operand1 <= '0;
          alu_operand2 <= '0;
          alu_mode     <= '0;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by randomized
// two-port traffic, with an ALU stub and a transaction-level reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_mode, req1_mode;
  logic        rsp0_valid, rsp1_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data, alu_operand1, alu_operand2, alu_out;
  logic [3:0]  alu_mode;
  logic        alu_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_mode(req1_mode),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_mode(alu_mode), .alu_en(alu_en), .alu_out(alu_out)
  );

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] m);
    case (m)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $signed(a) >>> b[4:0];
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      4'd10:   return a + (b << 2);
      default: return 32'h0;
    endcase
  endfunction

  // ALU stub: distinctive garbage when disabled or given an illegal mode
  assign alu_out = !alu_en ? 32'hdead_beef :
                   (alu_mode > 4'd10) ? 32'hbad0_0bad : ref_alu(alu_operand1, alu_operand2, alu_mode);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_en, alu_mode}, 0);
    chk("rst_data", rsp_data | alu_operand1 | alu_operand2, 0);
    rst = 1'b0;
  endtask

  // Requests already driven; waits for the grant, checks the whole transaction,
  // then releases the response and returns in the following IDLE cycle.
  task automatic transact(input int ep, input logic [31:0] ed, input logic ee,
                          input int hold, input string tag);
    int n = 0;
    rsp_ready = 1'b0;
    #1;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, ":gnt"}, {req1_ready, req0_ready}, (ep == 1) ? 2'b10 : 2'b01);
    @(negedge clk);
    if (ep == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    chk({tag, ":exec"}, {alu_en, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 5'b10000);
    @(negedge clk); #1;
    chk({tag, ":valid"}, {rsp1_valid, rsp0_valid}, (ep == 1) ? 2'b10 : 2'b01);
    chk({tag, ":data"}, rsp_data, ed);
    chk({tag, ":err"}, rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      chk({tag, ":hold"}, {rsp1_valid, rsp0_valid, rsp_err, alu_en, req1_ready, req0_ready},
          {(ep == 1) ? 2'b10 : 2'b01, ee, 3'b000});
      chk({tag, ":hold_data"}, rsp_data, ed);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk({tag, ":release"}, {rsp1_valid, rsp0_valid, alu_en}, 0);
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
    req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_mode = m;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
    req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_mode = m;
  endtask

  logic        pend [2];
  logic [31:0] o1 [2];
  logic [31:0] o2 [2];
  logic [3:0]  md [2];
  int          last_port;
  int          ep;
  logic        ee;

  initial begin
    req0_op1 = 0; req0_op2 = 0; req0_mode = 0;
    req1_op1 = 0; req1_op2 = 0; req1_mode = 0;

    // 1: single add on port 0
    do_reset();
    drive0(5, 7, 4'd0);
    transact(0, 12, 1'b0, 0, "t1");

    // 2: simultaneous requests from reset, port 0 wins the first tie
    do_reset();
    drive0(9, 4, 4'd1);
    drive1(32'hF0, 32'h0F, 4'd4);
    transact(0, 5, 1'b0, 0, "t2a");
    transact(1, 32'hFF, 1'b0, 0, "t2b");

    // 3: both held continuously, grants alternate
    drive0(1, 2, 4'd0);
    drive1(10, 3, 4'd1);
    transact(0, 3, 1'b0, 0, "t3a");
    drive0(6, 3, 4'd2);
    transact(1, 7, 1'b0, 0, "t3b");
    drive1(32'h80, 1, 4'd5);
    transact(0, 2, 1'b0, 0, "t3c");
    transact(1, 32'h100, 1'b0, 0, "t3d");

    // 4: back-pressure in DONE
    drive1(32'hA5A5_0000, 32'h0000_5A5A, 4'd3);
    transact(1, 32'hA5A5_5A5A, 1'b0, 5, "t4");

    // 5: illegal mode and the shifted-add mode
    drive0(123, 456, 4'd12);
    transact(0, 0, 1'b1, 0, "t5a");
    drive0(100, 3, 4'd10);
    transact(0, 112, 1'b0, 0, "t5b");

    // 6: reset during EXEC loses the operation
    drive0(3, 4, 4'd0);
    #1;
    chk("t6:gnt", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk); #1;
    chk("t6:exec", alu_en, 1'b1);
    rst = 1'b1; req0_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk); #1;
    chk("t6:rst_ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_en, alu_mode}, 0);
    chk("t6:rst_data", rsp_data | alu_operand1 | alu_operand2, 0);
    rst = 1'b0;
    drive0(20, 22, 4'd0);
    drive1(20, 22, 4'd1);
    transact(0, 42, 1'b0, 0, "t6a");
    transact(1, 32'hFFFF_FFFE, 1'b0, 0, "t6b");

    // Randomized traffic against a transaction-level model
    do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_port = 1;
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1 || (p == 1 && !pend[0]))) begin
          pend[p] = 1'b1;
          o1[p] = $urandom;
          o2[p] = $urandom;
          md[p] = 4'($urandom_range(0, 15));
        end
      end
      if (pend[0]) drive0(o1[0], o2[0], md[0]);
      if (pend[1]) drive1(o1[1], o2[1], md[1]);
      ep = (pend[0] && pend[1]) ? (1 - last_port) : (pend[0] ? 0 : 1);
      ee = (md[ep] > 4'd10);
      transact(ep, ee ? 32'h0 : ref_alu(o1[ep], o2[ep], md[ep]), ee, $urandom_range(0, 3), "rnd");
      pend[ep] = 1'b0;
      last_port = ep;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
